// File: rtl/byte_ram_ctrl.sv
// Byte-addressable data RAM with a MOV/MOC handshake, programmable wait states,
// sub-word loads/stores with optional sign extension, and misalignment/range error flagging.
module byte_ram_ctrl #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BIG_ENDIAN  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic              Signed,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = ADDR_W + 3;
  localparam int unsigned CW = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              sgn_q;

  logic [7:0]        mem [DEPTH];

  logic [IW-1:0]     idx [4];
  logic [7:0]        rb  [4];
  logic [7:0]        wb  [4];
  logic [3:0]        wen_c;
  logic [EW-1:0]     last_c;
  logic [15:0]       half_c;
  logic [31:0]       rd_c;
  logic              acc_err_c;
  logic              commit_c;

  // Byte lanes touched by the captured access; DEPTH is a power of two so indices never overrun.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k] = IW'(addr_q + ADDR_W'(k));
      rb[k]  = mem[idx[k]];
    end
  end

  // Alignment, reserved size and range checks on the captured request.
  always_comb begin
    acc_err_c = 1'b0;
    last_c    = EW'(addr_q);
    unique case (size_q)
      SZ_BYTE: last_c = EW'(addr_q);
      SZ_HALF: begin
        acc_err_c = addr_q[0];
        last_c    = EW'(addr_q) + EW'(1);
      end
      SZ_WORD: begin
        acc_err_c = |addr_q[1:0];
        last_c    = EW'(addr_q) + EW'(3);
      end
      default: acc_err_c = 1'b1;
    endcase
    if (last_c >= EW'(DEPTH)) acc_err_c = 1'b1;
  end

  // Load data: assemble per endianness, right-justify, then extend.
  always_comb begin
    half_c = (BIG_ENDIAN != 0) ? {rb[0], rb[1]} : {rb[1], rb[0]};
    rd_c   = '0;
    unique case (size_q)
      SZ_BYTE: rd_c = sgn_q ? {{24{rb[0][7]}}, rb[0]} : {24'd0, rb[0]};
      SZ_HALF: rd_c = sgn_q ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
      SZ_WORD: rd_c = (BIG_ENDIAN != 0) ? {rb[0], rb[1], rb[2], rb[3]}
                                        : {rb[3], rb[2], rb[1], rb[0]};
      default: rd_c = '0;
    endcase
  end

  // Store lanes: the low Size bytes of the write data, laid out per endianness.
  always_comb begin
    wen_c = '0;
    for (int k = 0; k < 4; k++) wb[k] = '0;
    unique case (size_q)
      SZ_BYTE: begin
        wen_c = 4'b0001;
        wb[0] = din_q[7:0];
      end
      SZ_HALF: begin
        wen_c = 4'b0011;
        wb[0] = (BIG_ENDIAN != 0) ? din_q[15:8] : din_q[7:0];
        wb[1] = (BIG_ENDIAN != 0) ? din_q[7:0]  : din_q[15:8];
      end
      SZ_WORD: begin
        wen_c = 4'b1111;
        for (int k = 0; k < 4; k++)
          wb[k] = (BIG_ENDIAN != 0) ? din_q[8*(3-k) +: 8] : din_q[8*k +: 8];
      end
      default: wen_c = '0;
    endcase
  end

  assign commit_c = (state == S_WAIT) && (cnt == '0) && !rw_q && !acc_err_c;

  // Array has no reset; a reset while in WAIT leaves state in IDLE so nothing commits.
  always_ff @(posedge Clk) begin
    if (commit_c) begin
      for (int k = 0; k < 4; k++)
        if (wen_c[k]) mem[idx[k]] <= wb[k];
    end
  end

  // Handshake state machine with registered DataOut/MOC/Err.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      DataOut <= '0;
      MOC     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Enable && MOV) begin
            addr_q <= Address;
            din_q  <= DataIn;
            rw_q   <= RW;
            size_q <= Size;
            sgn_q  <= Signed;
            cnt    <= CW'(WAIT_CYCLES);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            MOC   <= 1'b1;
            Err   <= acc_err_c;
            if (rw_q && !acc_err_c) DataOut <= rd_c;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          MOC   <= 1'b0;
          Err   <= 1'b0;
          state <= MOV ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          if (!MOV) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Scoreboard bench for byte_ram_ctrl: one instance with WAIT_CYCLES=1 and ADDR_W=10,
// a second with WAIT_CYCLES=3 for the reset-during-write scenario.
module tb_byte_ram_ctrl;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, en_a, en_b, mov, rw, sgn;
  logic [1:0]  size;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [31:0] dout_a, dout_b;
  logic        moc_a, moc_b, err_a, err_b;

  always #5 clk = ~clk;

  byte_ram_ctrl #(.DEPTH(512), .ADDR_W(10), .WAIT_CYCLES(1), .BIG_ENDIAN(1)) u_dut_a (
    .Clk(clk), .Reset(rst_a), .Enable(en_a), .MOV(mov), .RW(rw), .Size(size),
    .Signed(sgn), .Address(addr), .DataIn(din), .DataOut(dout_a), .MOC(moc_a), .Err(err_a)
  );

  byte_ram_ctrl #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(3), .BIG_ENDIAN(1)) u_dut_b (
    .Clk(clk), .Reset(rst_b), .Enable(en_b), .MOV(mov), .RW(rw), .Size(size),
    .Signed(sgn), .Address(addr[8:0]), .DataIn(din), .DataOut(dout_b), .MOC(moc_b), .Err(err_b)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_a, model_b;
  int          tests = 0;
  int          fails = 0;

  // One complete request; expected DataOut/Err are queued at issue and popped at MOC.
  task automatic access(input bit sel, input logic rw_i, input logic [1:0] sz, input logic sg,
                        input logic [9:0] ad, input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input bit disturb, input string name);
    exp_t e, got;
    int   lat, exp_lat;
    bit   seen;
    logic m, er;
    logic [31:0] d;
    exp_lat = sel ? 5 : 3;
    e.err   = exp_err;
    e.data  = (rw_i && !exp_err) ? exp_rd : (sel ? model_b : model_a);
    sb.push_back(e);
    @(negedge clk);
    rw = rw_i; size = sz; sgn = sg; addr = ad; din = wd; mov = 1'b1;
    en_a = !sel; en_b = sel;
    @(posedge clk);
    if (disturb) begin
      #1;
      en_a = 1'b0; en_b = 1'b0; addr = ~ad; rw = ~rw_i; din = ~wd; size = ~sz;
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = sel ? moc_b : moc_a;
    end
    got = sb.pop_front();
    tests++;
    if (seen !== 1'b1) begin
      fails++;
      $display("FAIL %s: MOC not seen within %0d cycles", name, lat);
    end else begin
      er = sel ? err_b : err_a;
      d  = sel ? dout_b : dout_a;
      tests++;
      if (lat !== exp_lat) begin
        fails++;
        $display("FAIL %s latency: got %0d need %0d", name, lat, exp_lat);
      end
      tests++;
      if (er !== got.err) begin
        fails++;
        $display("FAIL %s err: got %b need %b", name, er, got.err);
      end
      tests++;
      if (d !== got.data) begin
        fails++;
        $display("FAIL %s data: got %h need %h", name, d, got.data);
      end
      if (sel) model_b = got.data; else model_a = got.data;
      mov = 1'b0; en_a = 1'b0; en_b = 1'b0;
      @(negedge clk);
      m = sel ? moc_b : moc_a;
      tests++;
      if (m !== 1'b0) begin
        fails++;
        $display("FAIL %s moc_width: got %b need 0", name, m);
      end
    end
    mov = 1'b0; en_a = 1'b0; en_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; en_b = 1'b0; mov = 1'b0; rw = 1'b0; sgn = 1'b0;
    size = '0; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({dout_a, moc_a, err_a} !== 34'd0) begin
      fails++;
      $display("FAIL reset_a: got %h/%b/%b need 0/0/0", dout_a, moc_a, err_a);
    end
    tests++;
    if ({dout_b, moc_b, err_b} !== 34'd0) begin
      fails++;
      $display("FAIL reset_b: got %h/%b/%b need 0/0/0", dout_b, moc_b, err_b);
    end
    model_a = '0; model_b = '0;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_rw();
    access(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h1122_3344, 1'b0, 32'h0, 0, "wr_word_010");
    access(0, 1'b1, SZ_W, 1'b0, 10'h010, 32'h0, 1'b0, 32'h1122_3344, 0, "rd_word_010");
  endtask

  task automatic test_lanes();
    access(0, 1'b1, SZ_B, 1'b0, 10'h012, 32'h0, 1'b0, 32'h0000_0033, 0, "rd_byte_012");
    access(0, 1'b0, SZ_B, 1'b0, 10'h013, 32'hFFFF_FF80, 1'b0, 32'h0, 0, "wr_byte_013");
    access(0, 1'b1, SZ_B, 1'b1, 10'h013, 32'h0, 1'b0, 32'hFFFF_FF80, 0, "rd_sbyte_013");
    access(0, 1'b1, SZ_B, 1'b0, 10'h013, 32'h0, 1'b0, 32'h0000_0080, 0, "rd_ubyte_013");
    access(0, 1'b1, SZ_H, 1'b0, 10'h012, 32'h0, 1'b0, 32'h0000_3380, 0, "rd_half_012");
    access(0, 1'b1, SZ_H, 1'b1, 10'h012, 32'h0, 1'b0, 32'h0000_3380, 0, "rd_shalf_012");
    access(0, 1'b1, SZ_B, 1'b1, 10'h010, 32'h0, 1'b0, 32'h0000_0011, 0, "rd_sbyte_010");
    access(0, 1'b1, SZ_W, 1'b0, 10'h010, 32'h0, 1'b0, 32'h1122_3380, 0, "rd_word_010b");
  endtask

  task automatic test_errors();
    access(0, 1'b0, SZ_W, 1'b0, 10'h011, 32'hDEAD_BEEF, 1'b1, 32'h0, 0, "wr_misalign_011");
    access(0, 1'b1, SZ_W, 1'b0, 10'h010, 32'h0, 1'b0, 32'h1122_3380, 0, "rd_after_misalign");
    access(0, 1'b1, SZ_R, 1'b0, 10'h010, 32'h0, 1'b1, 32'h0, 0, "rd_size11");
    access(0, 1'b1, SZ_H, 1'b0, 10'h011, 32'h0, 1'b1, 32'h0, 0, "rd_half_011");
    access(0, 1'b1, SZ_W, 1'b0, 10'h1FE, 32'h0, 1'b1, 32'h0, 0, "rd_word_1fe");
    access(0, 1'b1, SZ_W, 1'b0, 10'h200, 32'h0, 1'b1, 32'h0, 0, "rd_word_200");
    access(0, 1'b1, SZ_B, 1'b0, 10'h200, 32'h0, 1'b1, 32'h0, 0, "rd_byte_200");
    access(0, 1'b0, SZ_W, 1'b0, 10'h1FC, 32'hCAFE_BABE, 1'b0, 32'h0, 0, "wr_word_1fc");
    access(0, 1'b1, SZ_W, 1'b0, 10'h1FC, 32'h0, 1'b0, 32'hCAFE_BABE, 0, "rd_word_1fc");
    access(0, 1'b0, SZ_H, 1'b0, 10'h1FE, 32'h0000_8001, 1'b0, 32'h0, 0, "wr_half_1fe");
    access(0, 1'b1, SZ_H, 1'b1, 10'h1FE, 32'h0, 1'b0, 32'hFFFF_8001, 0, "rd_shalf_1fe");
    access(0, 1'b1, SZ_B, 1'b0, 10'h1FF, 32'h0, 1'b0, 32'h0000_0001, 0, "rd_byte_1ff");
    access(0, 1'b1, SZ_W, 1'b0, 10'h1FC, 32'h0, 1'b0, 32'hCAFE_8001, 0, "rd_word_1fc_b");
  endtask

  task automatic test_hold_mov();
    int   pulses;
    exp_t e, got;
    logic [31:0] d;
    for (int rnd = 0; rnd < 2; rnd++) begin
      e.err  = 1'b0;
      e.data = 32'h1122_3380;
      sb.push_back(e);
      @(negedge clk);
      rw = 1'b1; size = SZ_W; sgn = 1'b0; addr = 10'h010; mov = 1'b1; en_a = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (moc_a === 1'b1) begin
          pulses++;
          if (pulses == 1) begin
            got = sb.pop_front();
            d   = dout_a;
            tests++;
            if (d !== got.data || err_a !== got.err) begin
              fails++;
              $display("FAIL hold_mov_data%0d: got %h/%b need %h/%b", rnd, d, err_a, got.data, got.err);
            end
          end
        end
      end
      if (pulses == 0) void'(sb.pop_front());
      tests++;
      if (pulses !== 1) begin
        fails++;
        $display("FAIL hold_mov_pulses%0d: got %0d need 1", rnd, pulses);
      end
      mov = 1'b0;
      repeat (2) @(negedge clk);
    end
    en_a = 1'b0;
    model_a = 32'h1122_3380;
  endtask

  task automatic test_isolation();
    access(0, 1'b1, SZ_W, 1'b0, 10'h010, 32'h0, 1'b0, 32'h1122_3380, 1, "rd_drop_enable");
    access(0, 1'b0, SZ_B, 1'b0, 10'h014, 32'h0000_005A, 1'b0, 32'h0, 1, "wr_drop_enable");
    access(0, 1'b1, SZ_B, 1'b0, 10'h014, 32'h0, 1'b0, 32'h0000_005A, 0, "rd_byte_014");
  endtask

  task automatic test_reset_mid_write();
    int pulses;
    access(1, 1'b0, SZ_W, 1'b0, 10'h020, 32'hA5A5_5A5A, 1'b0, 32'h0, 0, "b_prewrite");
    access(1, 1'b1, SZ_W, 1'b0, 10'h020, 32'h0, 1'b0, 32'hA5A5_5A5A, 0, "b_preread");
    @(negedge clk);
    rw = 1'b0; size = SZ_W; sgn = 1'b0; addr = 10'h020; din = 32'hDEAD_BEEF;
    mov = 1'b1; en_b = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (moc_b === 1'b1) pulses++;
    end
    rst_b = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (moc_b === 1'b1) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL rst_mid_wait_moc: got %0d pulses need 0", pulses);
    end
    tests++;
    if ({dout_b, moc_b, err_b} !== 34'd0) begin
      fails++;
      $display("FAIL rst_mid_wait_outs: got %h/%b/%b need 0/0/0", dout_b, moc_b, err_b);
    end
    mov = 1'b0; en_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    model_b = '0;
    @(negedge clk);
    access(1, 1'b1, SZ_W, 1'b0, 10'h020, 32'h0, 1'b0, 32'hA5A5_5A5A, 0, "b_read_after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_errors();
    test_hold_mov();
    test_isolation();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
